// File: rtl/conv_axis_out.sv
// conv_axis_out: output stage of the 3x3 convolution core.
// Buffers the core's free-running pixel stream in a small FWFT FIFO and
// presents it as an AXI4-Stream master. It counts the pixels of each frame,
// tags the last one with TLAST, pulses frame_done and flags dropped pixels.
// Optional feature macro: CONV_AXIS_TUSER_SOF_EN adds m_axis_tuser, which is
// high on the first pixel of each frame.
module conv_axis_out #(
  parameter int unsigned M      = 480,
  parameter int unsigned N      = 640,
  parameter int unsigned K      = 3,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
`ifdef CONV_AXIS_TUSER_SOF_EN
  output logic                     m_axis_tuser,
`endif
  output logic                     overflow,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned FRAME_PIX = (M - K + 1) * (N - K + 1);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
`ifdef CONV_AXIS_TUSER_SOF_EN
  localparam int unsigned TAG_W     = 2;
`else
  localparam int unsigned TAG_W     = 1;
`endif
  localparam int unsigned FW        = DATA_W + TAG_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [FW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic [CNT_W-1:0]  push_cnt;
  logic              last_dropped;

  logic              full;
  logic              empty;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              abort;
  logic              is_last_pix;
  logic [FW-1:0]     head;
  logic [FW-1:0]     wr_word;

  // FIFO status, handshake qualifiers and the word to be written
  always_comb begin
    full        = (count == LW'(DEPTH));
    empty       = (count == '0);
    head        = mem[rd_ptr];
    pop         = ~empty & m_axis_tready;
    is_last_pix = (push_cnt == CNT_W'(FRAME_PIX - 1));
    // A pop on a full FIFO frees the slot the incoming pixel needs
    accept      = (state == RUN) & start & in_valid & (~full | pop);
    drop        = (state == RUN) & start & in_valid & full & ~pop;
    abort       = ~start & ((state == RUN) | (state == DRAIN));
    wr_word     = '0;
    wr_word[DATA_W-1:0] = in_data;
    wr_word[DATA_W]     = is_last_pix;
`ifdef CONV_AXIS_TUSER_SOF_EN
    wr_word[DATA_W+1]   = (push_cnt == '0);
`endif
  end

  // FWFT head drives the stream; gated to zero while the FIFO is empty
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0 : head[DATA_W-1:0];
  assign m_axis_tlast  = ~empty & head[DATA_W];
`ifdef CONV_AXIS_TUSER_SOF_EN
  assign m_axis_tuser  = ~empty & head[DATA_W+1];
`endif
  assign level         = count;

  // FIFO storage; no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // FIFO pointers and occupancy; an abort flushes everything
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + LW'(accept) - LW'(pop);
    end
  end

  // Frame FSM: pixel counting, overflow flag and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      push_cnt     <= '0;
      last_dropped <= 1'b0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            push_cnt     <= '0;
            last_dropped <= 1'b0;
            overflow     <= 1'b0;
          end
        end
        RUN: begin
          if (!start) begin
            state        <= IDLE;
            push_cnt     <= '0;
            last_dropped <= 1'b0;
          end else if (accept || drop) begin
            // Dropped pixels still count so TLAST stays frame-aligned
            push_cnt <= push_cnt + CNT_W'(1);
            if (drop) begin
              overflow <= 1'b1;
            end
            if (is_last_pix) begin
              state <= DRAIN;
              if (drop) begin
                last_dropped <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (!start) begin
            state        <= IDLE;
            push_cnt     <= '0;
            last_dropped <= 1'b0;
          end else if ((pop && head[DATA_W]) || (last_dropped && empty)) begin
            // Without a tagged word to wait for, an empty FIFO ends the frame
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          push_cnt     <= '0;
          last_dropped <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_axis_out.sv
// tb_conv_axis_out: bench for conv_axis_out with a small 4x5 image
// (6 output pixels per frame) and a 4-deep FIFO. Compile with
// CONV_AXIS_TUSER_SOF_EN defined to also check m_axis_tuser.
module tb_conv_axis_out;

  localparam int unsigned M      = 4;
  localparam int unsigned N      = 5;
  localparam int unsigned K      = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int          FP     = (M - K + 1) * (N - K + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              ovf;
  logic              done;
  logic [$clog2(DEPTH):0] lvl;
`ifdef CONV_AXIS_TUSER_SOF_EN
  logic              tuser;
`endif

  conv_axis_out #(.M(M), .N(N), .K(K), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast),
`ifdef CONV_AXIS_TUSER_SOF_EN
    .m_axis_tuser(tuser),
`endif
    .overflow(ovf), .frame_done(done), .level(lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          last;
    bit          sof;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          s;
    bit          v;
    logic [31:0] d;
    bit          r;
    bit          e_valid;
    logic [31:0] e_data;
    bit          e_last;
    int          e_level;
    bit          e_ovf;
    bit          e_done;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model: pixel queue plus frame bookkeeping
  ent_t q[$];
  bit   m_acc, m_drn, m_done, m_lost, m_ovf;
  int   m_pix;

  ent_t obs[$];
  int   exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_acc = 0; m_drn = 0; m_done = 0; m_lost = 0; m_ovf = 0; m_pix = 0;
  endtask

  // One clock of the reference behaviour, from the inputs seen before the edge
  task automatic model_step(input bit s, input bit v, input logic [31:0] d, input bit r);
    bit   pop;
    bit   was_empty;
    bit   room;
    ent_t h;
    pop       = (q.size() != 0) && r;
    was_empty = (q.size() == 0);
    if (m_done) begin
      m_done = 0; m_pix = 0; m_lost = 0;
    end else if ((m_acc || m_drn) && !s) begin
      q.delete(); m_acc = 0; m_drn = 0; m_pix = 0; m_lost = 0;
    end else if (m_acc) begin
      room = (q.size() < DEPTH) || pop;
      if (pop) void'(q.pop_front());
      if (v) begin
        if (room) begin
          h.d = d; h.last = (m_pix == FP - 1); h.sof = (m_pix == 0);
          q.push_back(h);
        end else begin
          m_ovf = 1;
          if (m_pix == FP - 1) m_lost = 1;
        end
        m_pix++;
        if (m_pix == FP) begin
          m_acc = 0; m_drn = 1;
        end
      end
    end else if (m_drn) begin
      if (pop) begin
        h = q.pop_front();
        if (h.last) begin
          m_drn = 0; m_done = 1;
        end
      end else if (m_lost && was_empty) begin
        m_drn = 0; m_done = 1;
      end
    end else if (s) begin
      m_acc = 1; m_ovf = 0; m_pix = 0; m_lost = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1; start = 0; in_valid = 0; in_data = '0; tready = 0;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    obs.delete();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_level", lvl, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_frame_done", done, 0);
`ifdef CONV_AXIS_TUSER_SOF_EN
    chk("rst_tuser", tuser, 0);
`endif
  endtask

  // Drive one cycle, log handshakes, then compare against the model
  task automatic cyc(input bit s, input bit v, input logic [31:0] d, input bit r);
    bit          stall;
    logic [31:0] held;
    ent_t        e;
    start = s; in_valid = v; in_data = d; tready = r;
    if (tvalid && r) begin
      e.d = tdata; e.last = tlast;
`ifdef CONV_AXIS_TUSER_SOF_EN
      e.sof = tuser;
`else
      e.sof = 0;
`endif
      obs.push_back(e);
    end
    stall = tvalid && !r && s;
    held  = tdata;
    @(posedge clk); #1;
    model_step(s, v, d, r);
    if (done) done_cnt++;
    if (stall) begin
      chk("stall_tvalid_held", tvalid, 1);
      chk("stall_tdata_held", tdata, held);
    end
    chk("tvalid", tvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", tdata, q[0].d);
      chk("tlast", tlast, q[0].last);
`ifdef CONV_AXIS_TUSER_SOF_EN
      chk("tuser", tuser, q[0].sof);
`endif
    end
    chk("level", lvl, q.size());
    chk("overflow", ovf, m_ovf);
    chk("frame_done", done, m_done);
  endtask

  task automatic drain(input int budget);
    int base = done_cnt;
    int n    = 0;
    while (done_cnt == base && n < budget) begin
      cyc(1, 0, '0, 1);
      n++;
    end
    chk("drain_frame_done_seen", done_cnt != base, 1);
  endtask

  task automatic check_beats(input string nm, input int last_mask, input int user_mask);
    chk({nm, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      chk({nm, "_data"}, obs[i].d, exp_q[i]);
      chk({nm, "_last"}, obs[i].last, last_mask[i]);
`ifdef CONV_AXIS_TUSER_SOF_EN
      chk({nm, "_user"}, obs[i].sof, user_mask[i]);
`else
      if (user_mask < 0) chk({nm, "_user"}, obs[i].sof, 0);
`endif
    end
    obs.delete();
  endtask

  vec_t vecs[$];

  initial begin
    int base;
    bit s;
    // Directed vectors: full in-order frame, then full FIFO with simultaneous pop
    vecs = '{
      '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0},
      '{0, 1, 1, 1, 1,  1, 1, 0, 1, 0, 0},
      '{0, 1, 1, 2, 1,  1, 2, 0, 1, 0, 0},
      '{0, 1, 1, 3, 1,  1, 3, 0, 1, 0, 0},
      '{0, 1, 1, 4, 1,  1, 4, 0, 1, 0, 0},
      '{0, 1, 1, 5, 1,  1, 5, 0, 1, 0, 0},
      '{0, 1, 1, 6, 1,  1, 6, 1, 1, 0, 0},
      '{0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1},
      '{0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0},
      '{0, 1, 1, 1, 0,  1, 1, 0, 1, 0, 0},
      '{0, 1, 1, 2, 0,  1, 1, 0, 2, 0, 0},
      '{0, 1, 1, 3, 0,  1, 1, 0, 3, 0, 0},
      '{0, 1, 1, 4, 0,  1, 1, 0, 4, 0, 0},
      '{0, 1, 1, 5, 1,  1, 2, 0, 4, 0, 0}
    };
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cyc(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].r);
      chk("vec_tvalid", tvalid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk("vec_tdata", tdata, vecs[i].e_data);
        chk("vec_tlast", tlast, vecs[i].e_last);
      end
      chk("vec_level", lvl, vecs[i].e_level);
      chk("vec_overflow", ovf, vecs[i].e_ovf);
      chk("vec_frame_done", done, vecs[i].e_done);
    end

    // Overflow: word 5 dropped, word 6 accepted as FIFO pops and carries TLAST
    do_reset();
    base = done_cnt;
    cyc(1, 0, '0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 1, i, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_level_sat", lvl, DEPTH);
    cyc(1, 1, 6, 1);
    drain(20);
    cyc(1, 0, '0, 1);
    exp_q = '{1, 2, 3, 4, 6};
    check_beats("ovf_frame", 32'h10, 32'h1);
    chk("ovf_done_once", done_cnt - base, 1);

    // tready toggling every cycle
    do_reset();
    base = done_cnt;
    cyc(1, 0, '0, 0);
    for (int i = 1; i <= 6; i++) cyc(1, 1, i, (i % 2) == 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, '0, (i % 2) == 0);
    drain(20);
    cyc(1, 0, '0, 1);
    exp_q = '{1, 2, 3, 4, 5, 6};
    check_beats("toggle_frame", 32'h20, 32'h1);
    chk("toggle_no_ovf", ovf, 0);
    chk("toggle_done_once", done_cnt - base, 1);

    // Tagged last word dropped: frame ends on empty FIFO, no TLAST
    do_reset();
    base = done_cnt;
    cyc(1, 0, '0, 0);
    for (int i = 1; i <= 6; i++) cyc(1, 1, i, 0);
    chk("lost_ovf", ovf, 1);
    drain(20);
    cyc(1, 0, '0, 1);
    exp_q = '{1, 2, 3, 4};
    check_beats("lost_frame", 32'h0, 32'h1);
    chk("lost_done_once", done_cnt - base, 1);

    // Abort mid-frame flushes, keeps overflow; restart clears it
    do_reset();
    base = done_cnt;
    cyc(1, 0, '0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 1, i, 0);
    cyc(0, 0, '0, 0);
    chk("abort_level", lvl, 0);
    chk("abort_tvalid", tvalid, 0);
    chk("abort_ovf_kept", ovf, 1);
    cyc(1, 0, '0, 1);
    chk("restart_ovf_clear", ovf, 0);
    for (int i = 1; i <= 6; i++) cyc(1, 1, 10 + i, 1);
    drain(20);
    exp_q = '{11, 12, 13, 14, 15, 16};
    check_beats("abort_next_frame", 32'h20, 32'h1);
    chk("abort_done_once", done_cnt - base, 1);

    // Two back-to-back frames with start held high
    do_reset();
    cyc(1, 0, '0, 1);
    for (int i = 1; i <= 6; i++) cyc(1, 1, i, 1);
    drain(20);
    cyc(1, 0, '0, 1);
    cyc(1, 0, '0, 1);
    for (int i = 7; i <= 12; i++) cyc(1, 1, i, 1);
    drain(20);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    check_beats("b2b", 32'h820, 32'h41);

    // Randomised traffic against the model, light then heavy backpressure
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      s = 1;
      for (int c = 0; c < 3000; c++) begin
        if (s) s = ($urandom_range(0, 79) != 0);
        else   s = ($urandom_range(0, 2) == 0);
        cyc(s, $urandom_range(0, 99) < 70, $urandom,
            $urandom_range(0, 99) < (pass == 0 ? 75 : 30));
      end
      obs.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
